// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - per-cycle commit trace recorder with circular buffer and stream readout
//
// Records {ts, pc, instr, alu_result, reg_write, branch} on each enabled commit
// into a DEPTH-entry circular buffer. Capture modes are continuous wrap, one-shot
// fill, and pc-triggered post-capture. Frozen contents drain oldest-first.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   en                     commit strobe, sample this cycle
//   pc, instr, alu_result  committed instruction fields
//   reg_write, branch      committed control bits
//   mode                   00 continuous, 01 one-shot, 10 trigger, 11 as 01 (sampled at arm)
//   trig_pc, post_cnt      trigger address and entries kept after the trigger entry
//   arm, stop              clear-and-start pulse, freeze pulse
//   rd_valid/rd_ready      readout handshake, rd_data is the oldest held entry
//   state, count, overflow capture state, entries held, oldest entry lost since arm
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int DW   = TS_W + 2 * XLEN + 34
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] alu_result,
    input  logic            reg_write,
    input  logic            branch,
    input  logic [1:0]      mode,
    input  logic [XLEN-1:0] trig_pc,
    input  logic [AW:0]     post_cnt,
    input  logic            arm,
    input  logic            stop,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [DW-1:0]   rd_data,
    output logic [1:0]      state,
    output logic [AW:0]     count,
    output logic            overflow
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_CAPTURE = 2'b01;
    localparam logic [1:0] S_POST    = 2'b10;
    localparam logic [1:0] S_DONE    = 2'b11;

    localparam logic [1:0] M_CONT    = 2'b00;
    localparam logic [1:0] M_ONESHOT = 2'b01;
    localparam logic [1:0] M_TRIG    = 2'b10;

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] POST_MAX = AW'(DEPTH - 1);

    logic [1:0]      state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            overflow_q, overflow_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [AW-1:0]   post_q, post_d;
    logic [1:0]      mode_q, mode_d;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            capturing;
    logic            wr_en;
    logic            rd_fire;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   post_load;
    logic [DW-1:0]   wr_entry;

    assign capturing = (state_q == S_CAPTURE) || (state_q == S_POST);
    assign wr_entry  = {ts_q, pc, instr, alu_result, reg_write, branch};
    assign post_load = (post_cnt > (AW + 1)'(DEPTH - 1)) ? POST_MAX : post_cnt[AW-1:0];

    // With count == DEPTH the low AW bits are zero, so the oldest entry sits at wr_ptr.
    assign rd_ptr   = wr_ptr_q - count_q[AW-1:0];
    assign rd_valid = (state_q == S_DONE) && (count_q != '0);
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? mem_q[rd_ptr] : '0;

    assign state    = state_q;
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        ts_d       = ts_q + 1'b1;
        post_d     = post_q;
        mode_d     = mode_q;
        wr_en      = 1'b0;

        if (arm) begin
            state_d    = S_CAPTURE;
            count_d    = '0;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
            ts_d       = '0;
            post_d     = '0;
            mode_d     = (mode == 2'b11) ? M_ONESHOT : mode;
        end else if (stop && capturing) begin
            state_d = S_DONE;
        end else if (capturing && en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            // A full buffer overwrites its oldest entry; only wrapping modes get here.
            if (count_q == CNT_FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            if (state_q == S_POST) begin
                // post_q is never zero in POST: a zero load goes straight to DONE.
                post_d = post_q - 1'b1;
                if (post_q == AW'(1)) begin
                    state_d = S_DONE;
                end
            end else if (mode_q == M_ONESHOT) begin
                if (count_q == CNT_FULL - 1'b1) begin
                    state_d = S_DONE;
                end
            end else if (mode_q == M_TRIG && pc == trig_pc) begin
                post_d  = post_load;
                state_d = (post_load == '0) ? S_DONE : S_POST;
            end
        end else if (rd_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            ts_q       <= '0;
            post_q     <= '0;
            mode_q     <= M_CONT;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            ts_q       <= ts_d;
            post_q     <= post_d;
            mode_q     <= mode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule
